// File: rtl/led_pattern_ctrl.sv
// Command-driven LED pattern sequencer paced by an internal step prescaler.
// Latency: initial pattern and busy appear one edge after accept; first step STEP_CYCLES edges after accept.
// Backpressure: cmd_ready only in IDLE; a command offered in RUN or DONE must be held until accepted.
module led_pattern_ctrl #(
  parameter int STEP_CYCLES = 6_000_000,
  parameter int NUM_LED     = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [7:0]         cmd_steps,
  input  logic               abort,
  output logic [NUM_LED-1:0] led,
  output logic               busy,
  output logic               done
);

  localparam int                 CNT_W      = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [NUM_LED-1:0] ALT_INIT   = {(NUM_LED/2){2'b01}};
  localparam logic [NUM_LED-1:0] CHASE_INIT = NUM_LED'(1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_BLINK = 2'b01;
  localparam logic [1:0] MODE_ALT   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         mode, mode_nxt;
  logic [7:0]         steps, steps_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [7:0]         step_cnt, step_cnt_nxt;
  logic [7:0]         step_inc;
  logic [NUM_LED-1:0] led_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               tick;

  // Pattern shown right after a command is accepted.
  function automatic logic [NUM_LED-1:0] init_pattern(input logic [1:0] m);
    case (m)
      MODE_OFF:   return '0;
      MODE_BLINK: return '0;
      MODE_ALT:   return ALT_INIT;
      default:    return CHASE_INIT;
    endcase
  endfunction

  // Pattern after one step: OFF holds dark, BLINK/ALT invert, CHASE rotates left.
  function automatic logic [NUM_LED-1:0] advance(input logic [1:0] m,
                                                 input logic [NUM_LED-1:0] cur);
    case (m)
      MODE_OFF:   return '0;
      MODE_BLINK: return ~cur;
      MODE_ALT:   return ~cur;
      default:    return {cur[NUM_LED-2:0], cur[NUM_LED-1]};
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);
  assign tick      = (cnt == CNT_LAST);
  assign step_inc  = step_cnt + 8'd1;

  // Next-state and next-output logic; abort is checked before the step tick so it wins a tie.
  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode;
    steps_nxt    = steps;
    cnt_nxt      = cnt;
    step_cnt_nxt = step_cnt;
    led_nxt      = led;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        led_nxt  = '0;
        busy_nxt = 1'b0;
        if (cmd_valid) begin
          state_nxt    = RUN;
          mode_nxt     = cmd_mode;
          steps_nxt    = cmd_steps;
          cnt_nxt      = '0;
          step_cnt_nxt = 8'd0;
          busy_nxt     = 1'b1;
          led_nxt      = init_pattern(cmd_mode);
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          led_nxt   = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = tick ? '0 : cnt + CNT_ONE;
          if (tick) begin
            step_cnt_nxt = step_inc;
            if ((steps != 8'd0) && (step_inc == steps)) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
              led_nxt   = '0;
            end else begin
              led_nxt = advance(mode, led);
            end
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        led_nxt   = '0;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        led_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      mode     <= 2'b00;
      steps    <= 8'd0;
      cnt      <= '0;
      step_cnt <= 8'd0;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode     <= mode_nxt;
      steps    <= steps_nxt;
      cnt      <= cnt_nxt;
      step_cnt <= step_cnt_nxt;
      led      <= led_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with STEP_CYCLES=4, NUM_LED=4.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: held commands are checked against the reference model's accept point.
module tb_led_pattern_ctrl;

  localparam int STEP = 4;
  localparam int NL   = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [7:0]    cmd_steps;
  logic          abort;
  logic [NL-1:0] led;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 running, 2 done; m_k = edges elapsed since accept.
  int         m_phase = 0;
  int         m_k     = 0;
  logic [1:0] m_mode  = 2'b00;
  logic [7:0] m_steps = 8'd0;
  logic [3:0] m_led   = 4'b0000;
  logic       m_busy  = 1'b0;
  logic       m_done  = 1'b0;

  led_pattern_ctrl #(.STEP_CYCLES(STEP), .NUM_LED(NL)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  // Pattern after n completed steps, in closed form.
  function automatic logic [3:0] pattern(input logic [1:0] mode, input int n);
    case (mode)
      2'b00:   return 4'b0000;
      2'b01:   return (n % 2 == 1) ? 4'b1111 : 4'b0000;
      2'b10:   return (n % 2 == 1) ? 4'b1010 : 4'b0101;
      default: return 4'(1 << (n % 4));
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic [1:0] md,
                            input logic [7:0] st, input logic a);
    if (r) begin
      m_phase = 0; m_led = 4'b0000; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_done = 1'b0;
          if (v) begin
            m_phase = 1; m_mode = md; m_steps = st; m_k = 0;
            m_busy = 1'b1; m_led = pattern(md, 0);
          end
        end
        1: begin
          if (a) begin
            m_phase = 0; m_led = 4'b0000; m_busy = 1'b0;
          end else begin
            m_k++;
            if ((m_k % STEP == 0) && (m_steps != 8'd0) && (m_k / STEP == int'(m_steps))) begin
              m_phase = 2; m_done = 1'b1; m_busy = 1'b0; m_led = 4'b0000;
            end else begin
              m_led = pattern(m_mode, m_k / STEP);
            end
          end
        end
        default: begin
          m_phase = 0; m_done = 1'b0;
        end
      endcase
    end
  endtask

  // Advance one clock edge and update the model with the inputs seen at that edge.
  task automatic clk_step();
    logic r, v, a;
    logic [1:0] md;
    logic [7:0] st;
    r = rst_in; v = cmd_valid; a = abort; md = cmd_mode; st = cmd_steps;
    @(posedge clk_in);
    #1;
    model_edge(r, v, md, st, a);
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst_in = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'b11; cmd_steps = 8'd1; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      got = {led, busy, done, cmd_ready};
      n_checks++;
      if (got !== 7'b0000_0_0_1) begin
        n_fail++;
        $display("FAIL reset_c%0d: got led/busy/done/rdy=%b want 0000001", i, got);
      end
    end
    cmd_valid = 1'b0;
    rst_in    = 1'b0;
    clk_step();
    got = {led, busy, done, cmd_ready};
    n_checks++;
    if (got !== 7'b0000_0_0_1) begin
      n_fail++;
      $display("FAIL reset_release: got led/busy/done/rdy=%b want 0000001", got);
    end
  endtask

  task automatic test_blink_counted();
    logic [6:0] got, want, dir;
    logic       use_dir;
    cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_steps = 8'd3;
    clk_step();
    cmd_valid = 1'b0; cmd_mode = 2'b11; cmd_steps = 8'd9;
    for (int e = 1; e <= 14; e++) begin
      clk_step();
      got  = {led, busy, done, cmd_ready};
      want = {m_led, m_busy, m_done, (m_phase == 0)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL blink_model_e%0d: got %b want %b", e, got, want);
      end
      use_dir = 1'b1;
      case (e)
        1:       dir = 7'b0000_1_0_0;
        4:       dir = 7'b1111_1_0_0;
        8:       dir = 7'b0000_1_0_0;
        12:      dir = 7'b0000_0_1_0;
        13:      dir = 7'b0000_0_0_1;
        default: begin dir = 7'b0; use_dir = 1'b0; end
      endcase
      if (use_dir) begin
        n_checks++;
        if (got !== dir) begin
          n_fail++;
          $display("FAIL blink_edge%0d: got %b want %b", e, got, dir);
        end
      end
    end
  endtask

  task automatic test_chase_abort();
    logic [6:0] got, want;
    logic [3:0] dir;
    logic       saw_done;
    saw_done  = 1'b0;
    cmd_valid = 1'b1; cmd_mode = 2'b11; cmd_steps = 8'd0;
    clk_step();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      abort = (e == 18);
      clk_step();
      abort = 1'b0;
      got  = {led, busy, done, cmd_ready};
      want = {m_led, m_busy, m_done, (m_phase == 0)};
      saw_done = saw_done | done;
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL chase_model_e%0d: got %b want %b", e, got, want);
      end
      if (e % 4 == 0 && e <= 16) begin
        dir = 4'(1 << ((e / 4) % 4));
        n_checks++;
        if (led !== dir) begin
          n_fail++;
          $display("FAIL chase_edge%0d: led=%b want %b", e, led, dir);
        end
      end
      if (e == 18) begin
        n_checks++;
        if ({led, busy, done} !== 6'b0) begin
          n_fail++;
          $display("FAIL chase_abort: led/busy/done=%b want 000000", {led, busy, done});
        end
      end
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL chase_no_done: done pulsed=%b want 0", saw_done);
    end
  endtask

  task automatic test_alt_counted();
    logic [6:0] got, want;
    cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_steps = 8'd2;
    clk_step();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      clk_step();
      got  = {led, busy, done, cmd_ready};
      want = {m_led, m_busy, m_done, (m_phase == 0)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL alt_model_e%0d: got %b want %b", e, got, want);
      end
      if ((e == 1 && got !== 7'b0101_1_0_0) || (e == 4 && got !== 7'b1010_1_0_0) ||
          (e == 8 && got !== 7'b0000_0_1_0)) begin
        n_fail++;
        $display("FAIL alt_edge%0d: got %b", e, got);
      end
      if (e == 1 || e == 4 || e == 8) n_checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] got, want;
    cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_steps = 8'd2;
    clk_step();
    cmd_mode = 2'b11; cmd_steps = 8'd1;
    for (int e = 1; e <= 15; e++) begin
      abort = (e == 8);
      clk_step();
      abort = 1'b0;
      if (e == 9) cmd_valid = 1'b0;
      got  = {led, busy, done, cmd_ready};
      want = {m_led, m_busy, m_done, (m_phase == 0)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL b2b_model_e%0d: got %b want %b", e, got, want);
      end
      if (e == 8) begin
        n_checks++;
        if (got !== 7'b0000_0_0_1) begin
          n_fail++;
          $display("FAIL b2b_abort_tick: got %b want 0000001", got);
        end
      end
      if (e == 9) begin
        n_checks++;
        if (got !== 7'b0001_1_0_0) begin
          n_fail++;
          $display("FAIL b2b_accept: got %b want 0001100", got);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [6:0] got, want;
    cmd_valid = 1'b1; cmd_mode = 2'b11; cmd_steps = 8'd0;
    clk_step();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      rst_in = (e == 6);
      clk_step();
      got  = {led, busy, done, cmd_ready};
      want = {m_led, m_busy, m_done, (m_phase == 0)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rstmid_model_e%0d: got %b want %b", e, got, want);
      end
    end
    rst_in = 1'b0;
    n_checks++;
    if ({led, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear: led/busy=%b want 00000", {led, busy});
    end
    cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_steps = 8'd5;
    clk_step();
    cmd_valid = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      clk_step();
      got  = {led, busy, done, cmd_ready};
      want = {m_led, m_busy, m_done, (m_phase == 0)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rstmid_new_j%0d: got %b want %b", j, got, want);
      end
      if (j == 3 || j == 4) begin
        n_checks++;
        if (led !== ((j == 4) ? 4'b1111 : 4'b0000)) begin
          n_fail++;
          $display("FAIL rstmid_first_tick_j%0d: led=%b", j, led);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] got, want;
    for (int c = 0; c < 2000; c++) begin
      rst_in    = ($urandom_range(0, 149) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_mode  = 2'($urandom_range(0, 3));
      cmd_steps = 8'($urandom_range(0, 5));
      abort     = ($urandom_range(0, 39) == 0);
      clk_step();
      got  = {led, busy, done, cmd_ready};
      want = {m_led, m_busy, m_done, (m_phase == 0)};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random_c%0d: got %b want %b", c, got, want);
      end
    end
    rst_in = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_steps = 8'd0; abort = 1'b0;
    test_reset();
    test_blink_counted();
    test_chase_abort();
    test_alt_counted();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
